// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg -- shared definitions for the DCPU-16 register-file arbiter.
//   state_t    : arbiter FSM encoding (IDLE -> ACCESS -> DONE -> IDLE)
//   ADR_W      : register address width (A..J = 0..7)
//   DAT_W      : register data width
//   CNT_W      : width of the debug starvation counter
//   STARVE_DEF : default number of core grants allowed while debug waits
//   sat_inc()  : saturating increment for the starvation counter
package dcpu16_pkg;

  localparam int ADR_W      = 3;
  localparam int DAT_W      = 16;
  localparam int CNT_W      = 3;
  localparam int STARVE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter stops at its maximum rather than wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == 3'd7) ? 3'd7 : (cnt + 3'd1);
  endfunction

endpackage

// File: rtl/dcpu16_rfarb_sel.sv
// dcpu16_rfarb_sel -- combinational winner select and next starvation count.
//   c_req, d_req : pending requests from core and debug ports
//   cnt          : current count of core grants taken while debug waited
//   any_req      : at least one request is pending
//   grant_d      : debug wins this arbitration (core wins otherwise)
//   cnt_nxt      : counter value to load if this arbitration is taken
module dcpu16_rfarb_sel
  import dcpu16_pkg::*;
#(
  parameter int STARVE = STARVE_DEF
) (
  input  logic             c_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] cnt,
  output logic             any_req,
  output logic             grant_d,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE);

  // Core has priority unless it is idle or debug has waited STARVE core grants.
  always_comb begin
    any_req = c_req | d_req;
    grant_d = 1'b0;
    cnt_nxt = cnt;
    if (d_req && (!c_req || (cnt == STARVE_C))) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
    if (!any_req) begin
      cnt_nxt = cnt;
    end else if (grant_d) begin
      cnt_nxt = 3'd0;
    end else if (d_req) begin
      // core took the slot while debug was waiting
      cnt_nxt = sat_inc(cnt);
    end else begin
      cnt_nxt = 3'd0;
    end
  end

endmodule

// File: rtl/dcpu16_rfarb.sv
// dcpu16_rfarb -- arbitrates a core port and a debug port onto one register
// file. Each access takes three cycles: IDLE (arbitrate and latch the
// winner), ACCESS (drive the file, capture read data), DONE (ack winner).
//   clk, rst            : clock, asynchronous active-high reset
//   ena                 : global advance enable, low stalls everything
//   c_req/c_we/c_adr/c_dat, c_ack/c_dti : core request and response
//   d_req/d_we/d_adr/d_dat, d_ack/d_dti : debug request and response
//   rra, rwa, rwd, rwe  : register-file read/write address, data, enable
//   rrd                 : register-file combinational read data
module dcpu16_rfarb
  import dcpu16_pkg::*;
#(
  parameter int STARVE = STARVE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [ADR_W-1:0] c_adr,
  input  logic [DAT_W-1:0] c_dat,
  output logic             c_ack,
  output logic [DAT_W-1:0] c_dti,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [ADR_W-1:0] d_adr,
  input  logic [DAT_W-1:0] d_dat,
  output logic             d_ack,
  output logic [DAT_W-1:0] d_dti,
  output logic [ADR_W-1:0] rra,
  output logic [ADR_W-1:0] rwa,
  output logic [DAT_W-1:0] rwd,
  output logic             rwe,
  input  logic [DAT_W-1:0] rrd
);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               id_r;      // 1 = debug owns the current access
  logic               rwe_r;
  logic [ADR_W-1:0]   adr_r;
  logic [DAT_W-1:0]   rwd_r;
  logic               c_ack_r;
  logic               d_ack_r;
  logic [DAT_W-1:0]   c_dti_r;
  logic [DAT_W-1:0]   d_dti_r;

  logic               any_req_s;
  logic               grant_d_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               win_we_s;
  logic [ADR_W-1:0]   win_adr_s;
  logic [DAT_W-1:0]   win_dat_s;

  dcpu16_rfarb_sel #(
    .STARVE (STARVE)
  ) u_sel (
    .c_req   (c_req),
    .d_req   (d_req),
    .cnt     (cnt_r),
    .any_req (any_req_s),
    .grant_d (grant_d_s),
    .cnt_nxt (cnt_nxt_s)
  );

  // Route the winning port's request fields; the loser is never latched.
  always_comb begin
    win_we_s  = c_we;
    win_adr_s = c_adr;
    win_dat_s = c_dat;
    if (grant_d_s) begin
      win_we_s  = d_we;
      win_adr_s = d_adr;
      win_dat_s = d_dat;
    end else begin
      win_we_s  = c_we;
      win_adr_s = c_adr;
      win_dat_s = c_dat;
    end
  end

  // Arbiter FSM; the file-side and port-side output registers double as the
  // request latches, so everything advances only when ena is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      id_r    <= 1'b0;
      rwe_r   <= 1'b0;
      adr_r   <= 3'd0;
      rwd_r   <= 16'd0;
      c_ack_r <= 1'b0;
      d_ack_r <= 1'b0;
      c_dti_r <= 16'd0;
      d_dti_r <= 16'd0;
    end else if (ena) begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            id_r    <= grant_d_s;
            rwe_r   <= win_we_s;
            adr_r   <= win_adr_s;
            rwd_r   <= win_dat_s;
            cnt_r   <= cnt_nxt_s;
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // rrd still shows the pre-write value: the file updates on this edge
          rwe_r <= 1'b0;
          if (id_r) begin
            d_dti_r <= rrd;
          end else begin
            c_dti_r <= rrd;
          end
          c_ack_r <= ~id_r;
          d_ack_r <= id_r;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          rwe_r   <= 1'b0;
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // A stalled write must not reach the file, so the enable is gated by ena.
  assign rwe   = rwe_r & ena;
  assign rra   = adr_r;
  assign rwa   = adr_r;
  assign rwd   = rwd_r;
  assign c_ack = c_ack_r;
  assign d_ack = d_ack_r;
  assign c_dti = c_dti_r;
  assign d_dti = d_dti_r;

endmodule

// File: tb/tb_dcpu16_rfarb.sv
module tb_dcpu16_rfarb;

  localparam int STARVE = 4;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [15:0] dat;
  } op_t;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic        c_req, c_we, d_req, d_we;
  logic [2:0]  c_adr, d_adr, rra, rwa;
  logic [15:0] c_dat, d_dat, c_dti, d_dti, rwd, rrd;
  logic        c_ack, d_ack, rwe;

  // Register file behind the arbiter, plus an independent reference copy.
  logic [15:0] rf_mem    [8] = '{16'h0101, 16'h0202, 16'h1234, 16'h0404,
                                 16'h0505, 16'h00AA, 16'h0707, 16'h0808};
  logic [15:0] model_rf  [8] = '{16'h0101, 16'h0202, 16'h1234, 16'h0404,
                                 16'h0505, 16'h00AA, 16'h0707, 16'h0808};

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;   // core grants taken while debug was waiting

  op_t         cq[$], dq[$];
  logic [15:0] exp_c[$], exp_d[$];
  logic        exp_gid[$];
  logic [18:0] exp_wr[$];

  always #5 clk = ~clk;

  assign rrd = rf_mem[rra];

  always @(posedge clk) begin
    if (rwe) rf_mem[rwa] <= rwd;
  end

  dcpu16_rfarb #(.STARVE(STARVE)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_dat(c_dat),
    .c_ack(c_ack), .c_dti(c_dti),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_dat(d_dat),
    .d_ack(d_ack), .d_dti(d_dti),
    .rra(rra), .rwa(rwa), .rwd(rwd), .rwe(rwe), .rrd(rrd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction-level prediction: both queues start requesting together and
  // each requester keeps asking until its queue is empty.
  task automatic predict();
    int  i = 0;
    int  j = 0;
    bit  pick_d;
    op_t op;
    while (i < cq.size() || j < dq.size()) begin
      if (i < cq.size() && j < dq.size()) begin
        pick_d = (m_cnt == STARVE);
        m_cnt  = pick_d ? 0 : ((m_cnt == 7) ? 7 : m_cnt + 1);
      end else begin
        pick_d = (j < dq.size());
        m_cnt  = 0;
      end
      if (pick_d) begin op = dq[j]; j++; end
      else        begin op = cq[i]; i++; end
      if (pick_d) exp_d.push_back(model_rf[op.adr]);
      else        exp_c.push_back(model_rf[op.adr]);
      exp_gid.push_back(pick_d);
      if (op.we) begin
        exp_wr.push_back({op.adr, op.dat});
        model_rf[op.adr] = op.dat;
      end
    end
  endtask

  // ena_mode: 0 = always on, 1 = random stalls, 2 = 3-cycle stall in ACCESS
  task automatic run_round(input int ena_mode, input bit chk_lat);
    int ci = 0, di = 0, cyc = 0, c_first = 0;
    predict();
    c_req = (cq.size() > 0);
    if (c_req) {c_we, c_adr, c_dat} = cq[0];
    d_req = (dq.size() > 0);
    if (d_req) {d_we, d_adr, d_dat} = dq[0];
    while ((ci < cq.size() || di < dq.size()) && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      case (ena_mode)
        1:       ena = ($urandom_range(0, 3) != 0);
        2:       ena = !(cyc >= 1 && cyc <= 3);
        default: ena = 1'b1;
      endcase
      if (c_ack && c_first == 0) c_first = cyc;
      if (c_ack && ena) begin
        ci++;
        if (ci < cq.size()) {c_we, c_adr, c_dat} = cq[ci];
        else c_req = 1'b0;
      end
      if (d_ack && ena) begin
        di++;
        if (di < dq.size()) {d_we, d_adr, d_dat} = dq[di];
        else d_req = 1'b0;
      end
    end
    if (cyc >= 400) chk("round_timeout", cyc, 0);
    if (chk_lat) chk("c_latency", c_first, 2);
    ena = 1'b1; c_req = 1'b0; d_req = 1'b0;
    cq.delete(); dq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic op_t rnd_op();
    op_t o;
    o.we  = $urandom_range(0, 1);
    o.adr = $urandom_range(0, 7);
    o.dat = $urandom_range(0, 65535);
    return o;
  endfunction

  initial begin
    logic [15:0] save0;
    int          mode;
    rst = 1'b1; ena = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_adr = 3'd0; c_dat = 16'd0;
    d_req = 1'b0; d_we = 1'b0; d_adr = 3'd0; d_dat = 16'd0;

    // Scoreboard monitor: checks every completed access and file write.
    fork
      forever begin
        logic [18:0] w;
        logic        g;
        @(negedge clk);
        if (!rst) begin
          if (!ena) chk("rwe_during_stall", rwe, 0);
          if (rwe) begin
            if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
            else begin
              w = exp_wr.pop_front();
              chk("write_adr", rwa, w[18:16]);
              chk("write_dat", rwd, w[15:0]);
              chk("rra_eq_rwa", rra, rwa);
            end
          end
          if (ena && c_ack) begin
            chk("acks_exclusive", d_ack, 0);
            if (exp_c.size() == 0 || exp_gid.size() == 0) chk("unexpected_c_ack", 1, 0);
            else begin
              g = exp_gid.pop_front();
              chk("grant_order_c", g, 0);
              chk("c_dti", c_dti, exp_c.pop_front());
            end
          end
          if (ena && d_ack) begin
            if (exp_d.size() == 0 || exp_gid.size() == 0) chk("unexpected_d_ack", 1, 0);
            else begin
              g = exp_gid.pop_front();
              chk("grant_order_d", g, 1);
              chk("d_dti", d_dti, exp_d.pop_front());
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_c_ack", c_ack, 0);  chk("rst_d_ack", d_ack, 0);
    chk("rst_c_dti", c_dti, 0);  chk("rst_d_dti", d_dti, 0);
    chk("rst_rwe", rwe, 0);      chk("rst_rra", rra, 0);
    chk("rst_rwa", rwa, 0);      chk("rst_rwd", rwd, 0);
    rst = 1'b0; ena = 1'b1;
    @(posedge clk); #1;

    // Core read of reg 2
    cq.push_back('{we: 1'b0, adr: 3'd2, dat: 16'h5555});
    run_round(0, 1'b1);
    chk("core_read_dti", c_dti, 16'h1234);

    // Debug write of reg 5 returns the old value
    dq.push_back('{we: 1'b1, adr: 3'd5, dat: 16'hBEEF});
    run_round(0, 1'b0);
    chk("dbg_write_dti", d_dti, 16'h00AA);
    chk("dbg_write_file", rf_mem[5], 16'hBEEF);

    // Starvation: both held, grant order C,C,C,C,D,C,C,C,C,D
    for (int k = 0; k < 8; k++) cq.push_back(rnd_op());
    for (int k = 0; k < 2; k++) dq.push_back(rnd_op());
    run_round(0, 1'b0);

    // Write stalled for 3 cycles inside ACCESS
    cq.push_back('{we: 1'b1, adr: 3'd3, dat: 16'hC0DE});
    run_round(2, 1'b0);
    chk("stall_write_file", rf_mem[3], 16'hC0DE);

    // Reset in the middle of a write to reg 0
    save0 = rf_mem[0];
    c_req = 1'b1; c_we = 1'b1; c_adr = 3'd0; c_dat = ~save0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("abort_rwe", rwe, 0);     chk("abort_rwa", rwa, 0);
    chk("abort_rra", rra, 0);     chk("abort_rwd", rwd, 0);
    chk("abort_c_dti", c_dti, 0); chk("abort_d_dti", d_dti, 0);
    c_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_no_c_ack", c_ack, 0);
    end
    chk("abort_file0", rf_mem[0], save0);
    cq.push_back('{we: 1'b0, adr: 3'd0, dat: 16'h0000});
    run_round(0, 1'b1);

    // Randomized rounds with random stalls
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      if (mode != 1) for (int k = 0; k < $urandom_range(1, 6); k++) cq.push_back(rnd_op());
      if (mode != 0) for (int k = 0; k < $urandom_range(1, 3); k++) dq.push_back(rnd_op());
      run_round(1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("left_exp_c", exp_c.size(), 0);
    chk("left_exp_d", exp_d.size(), 0);
    chk("left_exp_wr", exp_wr.size(), 0);
    for (int k = 0; k < 8; k++) chk("final_file", rf_mem[k], model_rf[k]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
